// File: rtl/data_access_unit.sv
// Load/store sequencer between the core data port and a word-organised synchronous RAM.
// Accesses that straddle a word boundary are split into two aligned RAM accesses and merged on load.
module data_access_unit #(
  parameter int RAM_WORD_ADDR_WIDTH = 30
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic                           request_valid,
  output logic                           request_ready,
  input  logic [31:0]                    request_address,
  input  logic [31:0]                    request_write_data,
  input  logic [2:0]                     request_write_sections,
  output logic                           response_done,
  output logic [31:0]                    response_read_data,
  output logic                           response_error,
  output logic [RAM_WORD_ADDR_WIDTH-1:0] ram_address,
  output logic                           ram_write_enable,
  output logic [3:0]                     ram_byte_enable,
  output logic [31:0]                    ram_write_data,
  input  logic [31:0]                    ram_read_data
);
  localparam int AW = RAM_WORD_ADDR_WIDTH;

  typedef enum logic [1:0] {IDLE, ACCESS1, ACCESS2, RESPOND} state_t;

  // Second-word half of an access, parked until ACCESS1 has issued.
  typedef struct packed {
    logic          load;
    logic          split;
    logic          err;
    logic [1:0]    off;
    logic [AW-1:0] addr_hi;
    logic [3:0]    be_hi;
    logic [31:0]   wd_hi;
  } req_t;

  state_t state_q, state_d;
  req_t   req_q;
  logic   accept;

  // Request decode
  logic        legal, is_load, split_in;
  logic [3:0]  base;
  logic [2:0]  span, reach;
  logic [1:0]  offset;
  logic [7:0]  mask8;
  logic [63:0] data64;
  logic [AW-1:0] word_a, word_b;

  assign accept = request_valid && request_ready;
  assign offset = request_address[1:0];
  assign word_a = request_address[AW+1:2];
  assign word_b = word_a + {{(AW-1){1'b0}}, 1'b1};

  always_comb begin
    legal   = 1'b1;
    is_load = 1'b0;
    base    = 4'b1111;
    span    = 3'd4;
    case (request_write_sections)
      3'b000: is_load = 1'b1;
      3'b001: begin base = 4'b0001; span = 3'd1; end
      3'b011: begin base = 4'b0011; span = 3'd2; end
      3'b111: ;
      default: legal = 1'b0;
    endcase
  end

  assign reach    = {1'b0, offset} + span;
  assign split_in = reach > 3'd4;
  assign mask8    = {4'b0000, base} << offset;
  assign data64   = {32'd0, request_write_data} << {offset, 3'b000};

  // FSM
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = legal ? ACCESS1 : RESPOND;
      ACCESS1: state_d = req_q.split ? ACCESS2 : RESPOND;
      ACCESS2: state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Load merge: the low word was captured in ACCESS2, the live RAM output holds the last word read.
  logic [31:0] lo_q, rdata_q, merged;
  logic [63:0] cat, shifted;

  assign cat     = req_q.split ? {ram_read_data, lo_q} : {32'd0, ram_read_data};
  assign shifted = cat >> {req_q.off, 3'b000};
  assign merged  = shifted[31:0];

  // Datapath and registered RAM port
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      req_q            <= '0;
      lo_q             <= '0;
      rdata_q          <= '0;
      ram_address      <= '0;
      ram_write_enable <= 1'b0;
      ram_byte_enable  <= 4'b0000;
      ram_write_data   <= '0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          req_q.load    <= is_load;
          req_q.split   <= split_in;
          req_q.err     <= !legal;
          req_q.off     <= offset;
          req_q.addr_hi <= word_b;
          req_q.be_hi   <= mask8[7:4];
          req_q.wd_hi   <= data64[63:32];
          if (legal) begin
            ram_address      <= word_a;
            ram_write_enable <= !is_load;
            ram_byte_enable  <= is_load ? 4'b1111 : mask8[3:0];
            ram_write_data   <= is_load ? 32'd0 : data64[31:0];
          end
        end
        ACCESS1: if (req_q.split) begin
          ram_address      <= req_q.addr_hi;
          ram_write_enable <= !req_q.load;
          ram_byte_enable  <= req_q.load ? 4'b1111 : req_q.be_hi;
          ram_write_data   <= req_q.load ? 32'd0 : req_q.wd_hi;
        end else begin
          ram_write_enable <= 1'b0;
          ram_byte_enable  <= 4'b0000;
        end
        ACCESS2: begin
          lo_q             <= ram_read_data;
          ram_write_enable <= 1'b0;
          ram_byte_enable  <= 4'b0000;
        end
        RESPOND: if (req_q.load) rdata_q <= merged;
        default: ;
      endcase
    end
  end

  assign request_ready      = (state_q == IDLE);
  assign response_done      = (state_q == RESPOND) && !req_q.err;
  assign response_error     = (state_q == RESPOND) && req_q.err;
  assign response_read_data = (state_q == RESPOND && req_q.load) ? merged : rdata_q;

endmodule

// File: doc/data_access_unit.md
# data_access_unit

Sequencing stage between the core's data-memory port and a word-organised synchronous data RAM. It accepts one load or store per handshake using the core's three-bit write-section encoding. It splits accesses that cross a 32-bit word boundary into two aligned RAM accesses, and merges the RAM words back into a little-endian 32-bit load result.

## Interface
- RAM_WORD_ADDR_WIDTH, default 30: word-address width presented to the RAM.
- clock  in  1  single clock, rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- request_valid  in  1  core presents an access.
- request_ready  out  1  unit can accept; high only in IDLE.
- request_address  in  32  byte address.
- request_write_data  in  32  store data, right-aligned.
- request_write_sections  in  3  000 load word; 001 store byte; 011 store half; 111 store word.
- response_done  out  1  one-cycle pulse: access complete.
- response_read_data  out  32  load result; valid with done, held until next load completes.
- response_error  out  1  one-cycle pulse: illegal encoding rejected.
- ram_address  out  RAM_WORD_ADDR_WIDTH  word index.
- ram_write_enable  out  1  write strobe.
- ram_byte_enable  out  4  lane enables, bit i = bits 8i+7:8i.
- ram_write_data  out  32  lane-aligned write data.
- ram_read_data  in  32  RAM output, one cycle after address is presented with write_enable low.

## Operation
- States: IDLE, ACCESS1, ACCESS2, RESPOND.
- Accept when request_valid && request_ready. Latch address, data, sections.
- Encodings 010, 100, 101 and 110 are illegal:
  - go to RESPOND with response_error=1 instead of done;
  - no RAM access.
- offset = address[1:0]. span: load 4, byte 1, half 2, word 4. split = offset + span > 4.
- Lane mask:
  - base mask 4'b0001 / 4'b0011 / 4'b1111, zero-extended to 8 bits and shifted left by offset;
  - low nibble applies to word A = address[31:2];
  - high nibble applies to word A+1, computed modulo 2^RAM_WORD_ADDR_WIDTH so it wraps to 0.
- Store data: zero-extended to 64 bits, shifted left by 8*offset. Low 32 bits go to word A, high 32 bits go to word A+1.
- Loads: all four byte enables are asserted on every read.
  - Non-split: result = ram_read_data >> 8*offset.
  - Split: result = low 32 bits of {word A+1, word A} >> 8*offset.
- Transitions:
  - IDLE → ACCESS1 on a legal accept; IDLE → RESPOND on an illegal accept.
  - ACCESS1 → ACCESS2 if split, otherwise → RESPOND.
  - ACCESS2 → RESPOND.
  - RESPOND → IDLE.
- Lanes whose enable is 0 are never written; stores never modify other bytes.
- Reset values:
  - state IDLE; request_ready=1;
  - response_done=0, response_error=0, response_read_data=0;
  - ram_address=0, ram_write_enable=0, ram_byte_enable=0, ram_write_data=0.

## Timing
- Accept at edge N. RAM-side outputs are registered.
- ACCESS1 occupies cycle N+1: RAM signals for word A are driven.
- Non-split access:
  - RESPOND at N+2;
  - for a load, read data is captured from ram_read_data in this cycle;
  - latency 2.
- Split access:
  - ACCESS2 at N+2: word-A read data is captured, and word A+1 signals are driven;
  - RESPOND at N+3;
  - latency 3.
- Illegal access: RESPOND at N+1 with error pulse; latency 1.
- request_ready returns to 1 in the cycle after RESPOND. Minimum request spacing is 3 cycles non-split and 4 cycles split.
- ram_write_enable and ram_byte_enable are 0 in IDLE and RESPOND.
- request_* inputs are ignored while request_ready=0.
- reset_n low at any point:
  - forces the reset values immediately and asynchronously;
  - an in-flight split store whose second half has not issued is abandoned, and word A+1 is never written;
  - no done or error pulse is emitted for the aborted access.

## Test plan
- Store word 0xDEADBEEF at 0x10, then load 0x10:
  - store: ram_address=4, byte_enable=1111, done at N+2;
  - load: read_data=0xDEADBEEF at N+2.
- Store byte 0xA5 at 0x13: ram_address=4, byte_enable=1000, ram_write_data=0xA5000000. A following load of 0x10 returns 0xA5ADBEEF.
- Store word 0x11223344 at 0x16 (split):
  - cycle N+1: address 5, enables 1100, data 0x33440000;
  - cycle N+2: address 6, enables 0011, data 0x00001122;
  - done at N+3;
  - a load of 0x16 then returns 0x11223344 at N+3.
- Store half with write_sections 011 at 0xFFFFFFFF: first access to word 0x3FFFFFFF with enables 1000, second access to word 0 with enables 0001.
- request_write_sections=010: response_error pulse at N+1; ram_write_enable is never asserted; request_ready returns to 1 at N+2.
- Split store with reset_n deasserted during ACCESS1:
  - ram_write_enable drops to 0 asynchronously;
  - word A+1 is unchanged;
  - no done pulse;
  - request_ready=1 after reset release.
